// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI-to-regfile bridge.
//   spi_state_t : frame FSM states
//   FRAME_BITS, ADDR_W, DATA_W, REG_DEPTH, CMD_W_BIT : frame and regfile geometry
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned REG_DEPTH  = 8;
  localparam int unsigned CMD_W_BIT  = 7;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StDone
  } spi_state_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < REG_DEPTH;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// N-flop synchronizer with registered single-cycle edge pulses.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
// Pin-to-pulse latency is STAGES+1 clk cycles.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;
  logic              sync;

  // The chain and history flop are left unreset so they keep tracking the pin
  // through reset; that way a pin already low at reset release is not seen as
  // a fresh falling edge.
  always_ff @(posedge clk) begin
    chain_q <= {chain_q[STAGES-2:0], din};
    prev_q  <= sync;
  end

  assign sync = chain_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= sync & ~prev_q;
      fall_q <= ~sync & prev_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 peripheral giving an external host access to the 8 x 8b regfile.
// Frames are 16 bits: command byte (W, ignored[6:4], addr[3:0]) then data byte.
//   clk, rst          : system clock, synchronous active-high reset
//   sclk, cs_n, mosi  : asynchronous SPI pins
//   miso              : SPI data out, 0 whenever cs_n is high
//   o_en_wr           : one-cycle regfile write strobe
//   o_addr_wr, o_data : registered write address / data
//   o_addr_rd         : registered read address
//   i_rd_data         : regfile read data, combinational from o_addr_rd
//   o_frame_err       : one-cycle pulse when a frame is cut short by cs_n
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              o_en_wr,
  output logic [ADDR_W-1:0] o_addr_wr,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr_rd,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_frame_err
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CmdLast   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FrameLast = CNT_W'(FRAME_BITS - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk (clk),
    .rst (rst),
    .din (sclk),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .din (cs_n),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  // Data needs no edge detect; its chain matches the sclk chain depth.
  always_ff @(posedge clk) begin
    mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  spi_state_t state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-2:0] rx_q;
  logic              cmd_w_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] tx_q;
  logic              load_tx_q;
  logic              miso_q;
  logic              en_wr_q;
  logic              frame_err_q;
  logic [ADDR_W-1:0] addr_wr_q, addr_rd_q;
  logic [DATA_W-1:0] data_q;

  logic in_frame, cnt_clr, shift_en, cmd_done, frame_done, tx_shift, abort;
  logic [DATA_W-1:0] rx_byte;

  // Byte completed by the bit currently being sampled.
  assign rx_byte = {rx_q, mosi_s};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; a cs_n release always returns to idle.
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (cs_fall) state_d = StCmd;
        StCmd:  if (sclk_rise && bit_cnt_q == CmdLast) state_d = StData;
        StData: if (sclk_rise && bit_cnt_q == FrameLast) state_d = StDone;
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // Control strobes decoded from state and synchronized pin events.
  always_comb begin
    in_frame   = (state_q == StCmd) || (state_q == StData);
    abort      = cs_rise && in_frame;
    cnt_clr    = (state_q == StIdle) && cs_fall;
    shift_en   = sclk_rise && in_frame && !cs_rise;
    cmd_done   = shift_en && (state_q == StCmd) && (bit_cnt_q == CmdLast);
    frame_done = shift_en && (state_q == StData) && (bit_cnt_q == FrameLast);
    tx_shift   = sclk_fall && (state_q == StData) && !cs_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      cmd_w_q     <= 1'b0;
      cmd_addr_q  <= '0;
      tx_q        <= '0;
      load_tx_q   <= 1'b0;
      miso_q      <= 1'b0;
      en_wr_q     <= 1'b0;
      frame_err_q <= 1'b0;
      addr_wr_q   <= '0;
      addr_rd_q   <= '0;
      data_q      <= '0;
    end else begin
      frame_err_q <= abort;
      load_tx_q   <= cmd_done;
      en_wr_q     <= frame_done && cmd_w_q && addr_in_range(cmd_addr_q);

      if (cnt_clr)       bit_cnt_q <= '0;
      else if (shift_en) bit_cnt_q <= bit_cnt_q + 1'b1;

      if (shift_en) rx_q <= rx_byte[DATA_W-2:0];

      if (cmd_done) begin
        cmd_w_q    <= rx_byte[CMD_W_BIT];
        cmd_addr_q <= rx_byte[ADDR_W-1:0];
        if (!rx_byte[CMD_W_BIT]) addr_rd_q <= rx_byte[ADDR_W-1:0];
      end

      if (frame_done && cmd_w_q && addr_in_range(cmd_addr_q)) begin
        addr_wr_q <= cmd_addr_q;
        data_q    <= rx_byte;
      end

      // Read data is taken one cycle after o_addr_rd updates; out-of-range
      // reads and write frames shift out zeros.
      if (load_tx_q) begin
        tx_q <= (!cmd_w_q && addr_in_range(cmd_addr_q)) ? i_rd_data : '0;
      end else if (tx_shift) begin
        tx_q <= {tx_q[DATA_W-2:0], 1'b0};
      end

      if (state_q != StData) miso_q <= 1'b0;
      else if (tx_shift)     miso_q <= tx_q[DATA_W-1];
    end
  end

  assign miso        = miso_q & ~cs_n;
  assign o_en_wr     = en_wr_q;
  assign o_addr_wr   = addr_wr_q;
  assign o_data      = data_q;
  assign o_addr_rd   = addr_rd_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: table of full frames plus hand-written
// abort, over-length and mid-frame reset sequences against a small regfile model.
module tb_spi_reg_bridge;

  localparam int HALF = 8;  // clk cycles per sclk phase

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs_n, mosi;
  logic       miso, o_en_wr, o_frame_err;
  logic [3:0] o_addr_wr, o_addr_rd;
  logic [7:0] o_data, rd_data;

  always #5 clk = ~clk;

  spi_reg_bridge #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .o_en_wr    (o_en_wr),
    .o_addr_wr  (o_addr_wr),
    .o_data     (o_data),
    .o_addr_rd  (o_addr_rd),
    .i_rd_data  (rd_data),
    .o_frame_err(o_frame_err)
  );

  // Regfile model; out-of-range addresses return a nonzero pattern so any
  // missing masking in the DUT shows up on MISO.
  localparam logic [7:0] INIT [8] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC3, 8'h66, 8'h77};
  logic [7:0] mem [8];

  always @(posedge clk) begin
    if (rst) mem <= INIT;
    else if (o_en_wr && o_addr_wr < 4'd8) mem[o_addr_wr[2:0]] <= o_data;
  end

  assign rd_data = (o_addr_rd < 4'd8) ? mem[o_addr_rd[2:0]] : 8'hEE;

  // Pulse monitors count high cycles, so a stuck or stretched strobe shows.
  int wr_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_en_wr) wr_cnt++;
      if (o_frame_err) err_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [23:0] rx_word;

  // Master drives mosi while sclk is low and samples miso just before each rise.
  task automatic shift_bits(input logic [23:0] tx, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      mosi = tx[23-i];
      repeat (HALF) @(negedge clk);
      rx_word[23-i] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [23:0] tx, input int nbits);
    rx_word = '0;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(tx, 0, nbits - 1);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    int         exp_wr;
    logic [3:0] exp_waddr;
    logic [7:0] exp_wdata;
    logic [3:0] exp_raddr;
    logic       chk_rd;
    logic [7:0] exp_miso;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];
  int w0, e0;

  initial begin
    // Applied in order; the regfile model carries writes into later reads.
    vecs[0] = '{8'h83, 8'h5A, 1, 4'h3, 8'h5A, 4'h0, 1'b0, 8'h00};  // write 3
    vecs[1] = '{8'h05, 8'h00, 0, 4'h3, 8'h5A, 4'h5, 1'b1, 8'hC3};  // read 5
    vecs[2] = '{8'h8A, 8'hFF, 0, 4'h3, 8'h5A, 4'h5, 1'b0, 8'h00};  // write OOR
    vecs[3] = '{8'h0C, 8'h00, 0, 4'h3, 8'h5A, 4'hC, 1'b1, 8'h00};  // read OOR
    vecs[4] = '{8'h73, 8'h00, 0, 4'h3, 8'h5A, 4'h3, 1'b1, 8'h5A};  // read back 3
    vecs[5] = '{8'hF7, 8'h3C, 1, 4'h7, 8'h3C, 4'h3, 1'b0, 8'h00};  // write 7
    vecs[6] = '{8'h07, 8'h00, 0, 4'h7, 8'h3C, 4'h7, 1'b1, 8'h3C};  // read 7
    vecs[7] = '{8'h00, 8'h00, 0, 4'h7, 8'h3C, 4'h0, 1'b1, 8'hA5};  // read 0
    vecs[8] = '{8'h05, 8'hFF, 0, 4'h7, 8'h3C, 4'h5, 1'b1, 8'hC3};  // read, data ignored

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("reset miso", 32'(miso), 32'd0);
    check("reset en_wr", 32'(o_en_wr), 32'd0);
    check("reset frame_err", 32'(o_frame_err), 32'd0);
    check("reset addr_wr", 32'(o_addr_wr), 32'd0);
    check("reset data", 32'(o_data), 32'd0);
    check("reset addr_rd", 32'(o_addr_rd), 32'd0);

    for (int v = 0; v < NV; v++) begin
      w0 = wr_cnt; e0 = err_cnt;
      frame({vecs[v].cmd, vecs[v].dat, 8'h00}, 16);
      check($sformatf("v%0d wr_pulses", v), 32'(wr_cnt - w0), 32'(vecs[v].exp_wr));
      check($sformatf("v%0d frame_err", v), 32'(err_cnt - e0), 32'd0);
      check($sformatf("v%0d addr_wr", v), 32'(o_addr_wr), 32'(vecs[v].exp_waddr));
      check($sformatf("v%0d data", v), 32'(o_data), 32'(vecs[v].exp_wdata));
      check($sformatf("v%0d addr_rd", v), 32'(o_addr_rd), 32'(vecs[v].exp_raddr));
      check($sformatf("v%0d miso_cmd", v), 32'(rx_word[23:16]), 32'd0);
      if (vecs[v].chk_rd) begin
        check($sformatf("v%0d miso_data", v), 32'(rx_word[15:8]), 32'(vecs[v].exp_miso));
      end
    end

    // Abort after 10 bits, then the same frame in full.
    w0 = wr_cnt; e0 = err_cnt;
    frame(24'h817700, 10);
    check("abort wr_pulses", 32'(wr_cnt - w0), 32'd0);
    check("abort frame_err", 32'(err_cnt - e0), 32'd1);
    w0 = wr_cnt; e0 = err_cnt;
    frame(24'h817700, 16);
    check("after abort wr_pulses", 32'(wr_cnt - w0), 32'd1);
    check("after abort addr_wr", 32'(o_addr_wr), 32'h1);
    check("after abort data", 32'(o_data), 32'h77);
    check("after abort frame_err", 32'(err_cnt - e0), 32'd0);

    // Over-length frame: third byte ignored, MISO stays 0.
    w0 = wr_cnt; e0 = err_cnt;
    frame(24'h8211EE, 24);
    check("overlen wr_pulses", 32'(wr_cnt - w0), 32'd1);
    check("overlen addr_wr", 32'(o_addr_wr), 32'h2);
    check("overlen data", 32'(o_data), 32'h11);
    check("overlen miso_byte3", 32'(rx_word[7:0]), 32'd0);
    check("overlen frame_err", 32'(err_cnt - e0), 32'd0);

    // Reset after 12 bits; rest of that frame must be ignored.
    w0 = wr_cnt; e0 = err_cnt;
    rx_word = '0;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(24'h849900, 0, 11);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst miso", 32'(miso), 32'd0);
    check("midrst en_wr", 32'(o_en_wr), 32'd0);
    check("midrst frame_err", 32'(o_frame_err), 32'd0);
    check("midrst addr_wr", 32'(o_addr_wr), 32'd0);
    check("midrst data", 32'(o_data), 32'd0);
    check("midrst addr_rd", 32'(o_addr_rd), 32'd0);
    shift_bits(24'h849900, 12, 15);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    check("midrst wr_pulses", 32'(wr_cnt - w0), 32'd0);
    check("midrst err_pulses", 32'(err_cnt - e0), 32'd0);
    w0 = wr_cnt; e0 = err_cnt;
    frame(24'h849900, 16);
    check("after rst wr_pulses", 32'(wr_cnt - w0), 32'd1);
    check("after rst addr_wr", 32'(o_addr_wr), 32'h4);
    check("after rst data", 32'(o_data), 32'h99);
    check("after rst frame_err", 32'(err_cnt - e0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
